bcd_updown_timer: RTL and testbench
===================================

Name: bcd_updown_timer

Overview:
Parametrised successor to the team's 4-digit BCD up/down stopwatch. It provides an N-digit BCD up/down counter advanced by an internal prescaler tick. Additions over the previous generation are parallel load, synchronous clear, wrap or saturate mode at the count limits, and registered step/rollover status pulses. It sits between the user-control debounce logic and the seven-segment display mux.

Parameters:
NUM_DIGITS, 4, number of BCD digits (1..8)
TICK_DIV, 10000000, clk cycles per count step (>=1; 10000000 = 100 ms at 100 MHz)
DIV_W, 24, prescaler width; must satisfy 2^DIV_W >= TICK_DIV
SATURATE, 0, 0 = wrap at limits, 1 = hold at limits

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = prescaler runs and steps are applied
up  in  1  1 = count up, 0 = count down; sampled at each step
clear  in  1  synchronous clear of digits and prescaler
load  in  1  synchronous parallel load of digits
load_value  in  4*NUM_DIGITS  BCD load value, digit 0 in [3:0]
digits  out  4*NUM_DIGITS  registered BCD count, digit 0 in [3:0]
step  out  1  registered 1-cycle pulse on every edge where a count step is applied
rollover  out  1  registered 1-cycle pulse on a wrap (SATURATE=0) or a blocked step at a limit (SATURATE=1)
at_zero  out  1  combinational: all digits == 0
at_max  out  1  combinational: all digits == 9

Behaviour:
- Reset values: digits = 0, prescaler = 0, step = 0, rollover = 0; at_zero = 1 and at_max = 0 follow from digits.
- Priority per edge: reset > clear > load > step.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while enable = 1 and holds while enable = 0.
  - step_now = enable && (prescaler == TICK_DIV-1); on that edge the prescaler returns to 0.
  - With TICK_DIV = 1, step_now = enable every cycle.
- clear: digits <= 0, prescaler <= 0, step/rollover <= 0. Takes effect regardless of enable.
- load (clear = 0):
  - digits <= load_value, with any nibble > 9 clamped to 9.
  - prescaler <= 0; no step that cycle; step/rollover <= 0.
- Step, up = 1:
  - Digit 0 increments; a digit at 9 becomes 0 and carries into the next digit.
  - All-nines: SATURATE=0 gives all zeros with rollover = 1; SATURATE=1 keeps digits unchanged with rollover = 1.
- Step, up = 0:
  - Digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
  - All-zeros: SATURATE=0 gives all nines with rollover = 1; SATURATE=1 keeps digits unchanged with rollover = 1.
- Latency: digits, step and rollover all update on the same edge that step_now is true. step = 1 for exactly that cycle, including a saturated step where digits do not change.
- No step: digits hold their value; step = 0 and rollover = 0 on the next edge.
- Next-state logic is fully assigned on every path. No latches; every next-state value defaults to hold.
- Changing up between steps takes effect at the next step only. It does not reset the prescaler.
- Deasserting enable mid-period freezes the prescaler; re-enabling resumes the remaining period.
- Reset or clear mid-period discards partial prescaler progress.
- Digits hold only values 0..9 at all times.

Test Plan:
Parameters for all scenarios: NUM_DIGITS = 3, TICK_DIV = 4.

1. Reset, then enable = 1, up = 1 for 48 cycles -> step pulses on cycles 4, 8, …, 48; digits = 0x012; at_zero = 0.
2. SATURATE = 0: load 0x999, then one step with up = 1 -> digits = 0x000 and rollover = 1 for that cycle. Load 0x000, then one step with up = 0 -> digits = 0x999 and rollover = 1.
3. SATURATE = 1: load 0x999, then three steps up -> digits stay 0x999, step and rollover pulse on each step, at_max = 1. Then one step down -> digits = 0x998.
4. Load 0x0A5 (invalid tens digit) -> digits = 0x095. Assert load on the same edge as step_now -> load value wins, no step pulse, prescaler restarts (next step 4 cycles later).
5. Hold enable = 0 for 10 cycles at prescaler = 2 -> no step. Re-enable -> step occurs after 2 more cycles.
6. Assert reset together with clear and load mid-count -> digits = 0x000, step = 0, rollover = 0. Assert clear alone during enable -> digits = 0x000, and the first step follows 4 cycles later.

Source files
------------

// File: rtl/bcd_updown_timer.sv
// N-digit BCD up/down counter stepped by an internal prescaler tick, with
// parallel load, synchronous clear, wrap/saturate limits and status pulses.
module bcd_updown_timer #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 10000000,
   parameter int DIV_W      = 24,
   parameter int SATURATE   = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    up,
   input  logic                    clear,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    step,
   output logic                    rollover,
   output logic                    at_zero,
   output logic                    at_max
);

   localparam int W = 4 * NUM_DIGITS;
   localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] prescaler;
   logic             step_now;
   logic [W-1:0]     inc_digits;
   logic [W-1:0]     dec_digits;
   logic [W-1:0]     clamped_load;
   logic [W-1:0]     step_digits;
   logic             at_limit;
   logic             carry;
   logic             borrow;

   assign step_now = enable && (prescaler == TICK_LAST);

   // Ripple increment/decrement across digits; a full wrap falls out naturally
   // (all nines -> all zeros, all zeros -> all nines).
   always_comb begin
      inc_digits   = digits;
      dec_digits   = digits;
      clamped_load = load_value;
      carry        = 1'b1;
      borrow       = 1'b1;
      at_zero      = 1'b1;
      at_max       = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digits[4*i +: 4] != 4'd0) at_zero = 1'b0;
         if (digits[4*i +: 4] != 4'd9) at_max = 1'b0;
         if (carry) begin
            if (digits[4*i +: 4] >= 4'd9) begin
               inc_digits[4*i +: 4] = 4'd0;
            end else begin
               inc_digits[4*i +: 4] = digits[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (digits[4*i +: 4] == 4'd0) begin
               dec_digits[4*i +: 4] = 4'd9;
            end else begin
               dec_digits[4*i +: 4] = digits[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
         if (load_value[4*i +: 4] > 4'd9) clamped_load[4*i +: 4] = 4'd9;
      end
   end

   always_comb begin
      at_limit    = up ? at_max : at_zero;
      step_digits = up ? inc_digits : dec_digits;
      if ((SATURATE != 0) && at_limit) step_digits = digits;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         digits    <= '0;
         prescaler <= '0;
         step      <= 1'b0;
         rollover  <= 1'b0;
      end else if (load) begin
         digits    <= clamped_load;
         prescaler <= '0;
         step      <= 1'b0;
         rollover  <= 1'b0;
      end else begin
         step     <= 1'b0;
         rollover <= 1'b0;
         if (enable) prescaler <= step_now ? '0 : prescaler + 1'b1;
         if (step_now) begin
            digits   <= step_digits;
            step     <= 1'b1;
            rollover <= at_limit;
         end
      end
   end

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Directed bench for bcd_updown_timer: a wrapping and a saturating instance
// share one stimulus stream (3 digits, 4-cycle tick).
module tb_bcd_updown_timer;

   localparam int ND = 3;
   localparam int W  = 4 * ND;

   logic         clk = 1'b0;
   logic         reset, enable, up, clear, load;
   logic [W-1:0] load_value;
   logic [W-1:0] digits_w, digits_s;
   logic         step_w, step_s, rollover_w, rollover_s;
   logic         at_zero_w, at_zero_s, at_max_w, at_max_s;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   bcd_updown_timer #(.NUM_DIGITS(ND), .TICK_DIV(4), .DIV_W(3), .SATURATE(0)) dut_wrap (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
      .load(load), .load_value(load_value), .digits(digits_w), .step(step_w),
      .rollover(rollover_w), .at_zero(at_zero_w), .at_max(at_max_w)
   );

   bcd_updown_timer #(.NUM_DIGITS(ND), .TICK_DIV(4), .DIV_W(3), .SATURATE(1)) dut_sat (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
      .load(load), .load_value(load_value), .digits(digits_s), .step(step_s),
      .rollover(rollover_s), .at_zero(at_zero_s), .at_max(at_max_s)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_load(input logic [W-1:0] v);
      load = 1'b1;
      load_value = v;
      tick(1);
      load = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0;
      load_value = '0;
      tick(2);
      check("reset_digits", digits_w, 12'h000);
      check("reset_step", {11'd0, step_w}, 12'd0);
      check("reset_rollover", {11'd0, rollover_w}, 12'd0);
      check("reset_at_zero", {11'd0, at_zero_w}, 12'd1);
      check("reset_at_max", {11'd0, at_max_w}, 12'd0);

      // 1: count up twelve steps, one every 4 cycles
      reset = 1'b0; enable = 1'b1; up = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick(3);
         check("s1_no_step", {11'd0, step_w}, 12'd0);
         tick(1);
         check("s1_step", {11'd0, step_w}, 12'd1);
         if (k == 9)  check("s1_digits9", digits_w, 12'h009);
         if (k == 10) check("s1_digits10", digits_w, 12'h010);
      end
      check("s1_digits_w", digits_w, 12'h012);
      check("s1_digits_s", digits_s, 12'h012);
      check("s1_at_zero", {11'd0, at_zero_w}, 12'd0);

      // 2: limits up and down
      do_load(12'h999);
      check("s2_load_at_max", {11'd0, at_max_w}, 12'd1);
      tick(4);
      check("s2_wrap_up", digits_w, 12'h000);
      check("s2_wrap_up_roll", {11'd0, rollover_w}, 12'd1);
      check("s2_sat_up", digits_s, 12'h999);
      check("s2_sat_up_roll", {11'd0, rollover_s}, 12'd1);
      tick(1);
      check("s2_roll_clears", {11'd0, rollover_w}, 12'd0);
      up = 1'b0;
      do_load(12'h000);
      tick(4);
      check("s2_wrap_dn", digits_w, 12'h999);
      check("s2_wrap_dn_roll", {11'd0, rollover_w}, 12'd1);
      check("s2_sat_dn", digits_s, 12'h000);
      check("s2_sat_dn_roll", {11'd0, rollover_s}, 12'd1);
      check("s2_sat_at_zero", {11'd0, at_zero_s}, 12'd1);

      // 3: saturated steps still pulse step and rollover
      up = 1'b1;
      do_load(12'h999);
      for (int k = 0; k < 3; k++) begin
         tick(4);
         check("s3_sat_digits", digits_s, 12'h999);
         check("s3_sat_step", {11'd0, step_s}, 12'd1);
         check("s3_sat_roll", {11'd0, rollover_s}, 12'd1);
         check("s3_sat_at_max", {11'd0, at_max_s}, 12'd1);
      end
      check("s3_wrap_digits", digits_w, 12'h002);
      up = 1'b0;
      tick(4);
      check("s3_sat_down", digits_s, 12'h998);
      check("s3_sat_down_step", {11'd0, step_s}, 12'd1);
      check("s3_sat_down_roll", {11'd0, rollover_s}, 12'd0);
      check("s3_wrap_down", digits_w, 12'h001);

      // 4: clamped load, then load colliding with step_now
      up = 1'b1;
      do_load(12'h0A5);
      check("s4_clamp_w", digits_w, 12'h095);
      check("s4_clamp_s", digits_s, 12'h095);
      tick(3);
      do_load(12'h321);
      check("s4_load_wins", digits_w, 12'h321);
      check("s4_load_no_step", {11'd0, step_w}, 12'd0);
      tick(3);
      check("s4_restart_no_step", {11'd0, step_w}, 12'd0);
      tick(1);
      check("s4_restart_step", {11'd0, step_w}, 12'd1);
      check("s4_restart_digits", digits_w, 12'h322);

      // 5: freeze prescaler at 2 for 10 cycles
      tick(2);
      enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         check("s5_frozen_step", {11'd0, step_w}, 12'd0);
      end
      check("s5_frozen_digits", digits_w, 12'h322);
      enable = 1'b1;
      tick(1);
      check("s5_resume_no_step", {11'd0, step_w}, 12'd0);
      tick(1);
      check("s5_resume_step", {11'd0, step_w}, 12'd1);
      check("s5_resume_digits", digits_w, 12'h323);

      // 6: reset beats clear and load on a step edge; then clear alone
      tick(3);
      reset = 1'b1; clear = 1'b1; load = 1'b1; load_value = 12'h777;
      tick(1);
      reset = 1'b0; clear = 1'b0; load = 1'b0;
      check("s6_reset_digits", digits_w, 12'h000);
      check("s6_reset_step", {11'd0, step_w}, 12'd0);
      check("s6_reset_roll", {11'd0, rollover_w}, 12'd0);
      tick(4);
      check("s6_after_reset", digits_w, 12'h001);
      tick(2);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("s6_clear_digits", digits_w, 12'h000);
      check("s6_clear_step", {11'd0, step_w}, 12'd0);
      tick(3);
      check("s6_clear_no_step", {11'd0, step_w}, 12'd0);
      tick(1);
      check("s6_clear_step4", {11'd0, step_w}, 12'd1);
      check("s6_clear_digits4", digits_w, 12'h001);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
